// File: rtl/hazard_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit_pkg
//  Description : Shared register-address constants and the multi-cycle
//                tracker state encoding for the hazard control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_control_unit_pkg;

    // Register-file address width and the hard-wired zero register
    localparam int                c_REG_AW = 4;
    localparam logic [c_REG_AW-1:0] c_R_ZERO = 4'd0;

    // Width of the multi-cycle latency down-counter
    localparam int                c_CNT_W  = 4;

    // Multi-cycle unit occupancy state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_t;

endpackage : hazard_control_unit_pkg
`default_nettype wire

// File: rtl/hazard_control_unit_mc_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit_mc_tracker
//  Description : Tracks the single non-pipelined multi-cycle unit: occupancy,
//                latency countdown and the in-flight destination register.
//                Flags the writeback cycle on the last busy cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit_mc_tracker
    import hazard_control_unit_pkg::*;
#(
    // Cycles from issue edge to writeback cycle, inclusive (legal 2..15)
    parameter int MC_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_issue,
    input  logic [c_REG_AW-1:0] i_rd,
    input  logic                i_regwrite,
    output logic                o_mc_busy,
    output logic                o_mc_wb,
    output logic [c_REG_AW-1:0] o_mc_wb_rd,
    output logic [c_REG_AW-1:0] o_pend_rd,
    output logic                o_pend_valid
);

    // Counter load value: the issue edge itself counts as the first of
    // MC_LATENCY cycles, so the count runs MC_LATENCY-1 down to 0.
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = 4'(MC_LATENCY - 1);

    mc_state_t           r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_REG_AW-1:0] r_pend_rd;
    logic                r_pend_valid;
    logic                w_last;

    assign w_last = (r_state == ST_BUSY) && (r_cnt == '0);

    // Occupancy FSM: load on issue, count down, retire after the last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_pend_rd    <= c_R_ZERO;
            r_pend_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_issue) begin
                        r_state      <= ST_BUSY;
                        r_cnt        <= c_CNT_INIT;
                        r_pend_rd    <= i_rd;
                        r_pend_valid <= i_regwrite && (i_rd != c_R_ZERO);
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state      <= ST_IDLE;
                        r_pend_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_pend_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_mc_busy    = (r_state == ST_BUSY);
    assign o_mc_wb      = w_last && r_pend_valid;
    // Destination is only meaningful alongside the writeback strobe
    assign o_mc_wb_rd   = o_mc_wb ? r_pend_rd : c_R_ZERO;
    assign o_pend_rd    = r_pend_rd;
    assign o_pend_valid = r_pend_valid;

endmodule : hazard_control_unit_mc_tracker
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit
//  Description : Issue-side hazard control at the IF/ID -> ID/EX boundary.
//                Stalls on load-use and on structural/RAW/WAW conflicts with
//                the multi-cycle unit; a taken-branch flush overrides stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    // Cycles from issue edge to writeback cycle, inclusive (legal 2..15)
    parameter int MC_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_ifid_valid,
    input  logic [c_REG_AW-1:0] i_ifid_rs,
    input  logic [c_REG_AW-1:0] i_ifid_rt,
    input  logic                i_ifid_uses_rs,
    input  logic                i_ifid_uses_rt,
    input  logic [c_REG_AW-1:0] i_ifid_rd,
    input  logic                i_ifid_regwrite,
    input  logic                i_ifid_multicycle,
    input  logic                i_idex_memread,
    input  logic [c_REG_AW-1:0] i_idex_rt,
    input  logic                i_flush,
    output logic                o_pc_write,
    output logic                o_ifid_write,
    output logic                o_idex_bubble,
    output logic                o_mc_start,
    output logic                o_mc_busy,
    output logic                o_mc_wb,
    output logic [c_REG_AW-1:0] o_mc_wb_rd
);

    logic                w_mc_busy;
    logic [c_REG_AW-1:0] w_pend_rd;
    logic                w_pend_valid;
    logic                w_load_use;
    logic                w_raw;
    logic                w_waw;
    logic                w_mc_hazard;
    logic                w_stall;
    logic                w_issue;

    // A load in EX whose destination feeds this instruction (r0 never does)
    assign w_load_use = i_idex_memread && (i_idex_rt != c_R_ZERO) &&
                        ((i_ifid_uses_rs && (i_idex_rt == i_ifid_rs)) ||
                         (i_ifid_uses_rt && (i_idex_rt == i_ifid_rt)));

    // pend_valid is already cleared for r0 destinations, so no r0 test here
    assign w_raw = w_pend_valid &&
                   ((i_ifid_uses_rs && (i_ifid_rs == w_pend_rd)) ||
                    (i_ifid_uses_rt && (i_ifid_rt == w_pend_rd)));
    assign w_waw = w_pend_valid && i_ifid_regwrite && (i_ifid_rd == w_pend_rd);

    // Conflicts with the multi-cycle unit only matter while it is occupied;
    // holding through the writeback cycle avoids relying on regfile bypass.
    assign w_mc_hazard = w_mc_busy && (i_ifid_multicycle || w_raw || w_waw);

    // A flushed slot is being squashed anyway, so it never stalls or issues
    assign w_stall = i_ifid_valid && !i_flush && (w_load_use || w_mc_hazard);
    assign w_issue = i_ifid_valid && i_ifid_multicycle && !i_flush && !w_stall;

    assign o_pc_write    = !w_stall;
    assign o_ifid_write  = !w_stall;
    assign o_idex_bubble = w_stall || i_flush;
    assign o_mc_start    = w_issue;
    assign o_mc_busy     = w_mc_busy;

    hazard_control_unit_mc_tracker #(
        .MC_LATENCY (MC_LATENCY)
    ) u_mc_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_issue      (w_issue),
        .i_rd         (i_ifid_rd),
        .i_regwrite   (i_ifid_regwrite),
        .o_mc_busy    (w_mc_busy),
        .o_mc_wb      (o_mc_wb),
        .o_mc_wb_rd   (o_mc_wb_rd),
        .o_pend_rd    (w_pend_rd),
        .o_pend_valid (w_pend_valid)
    );

endmodule : hazard_control_unit
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_control_unit
//  Description : Self-checking bench for hazard_control_unit (MC_LATENCY=4).
//                Expected outputs are queued as each cycle is driven and
//                compared against the sampled outputs per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       ifid_write;
        logic       idex_bubble;
        logic       mc_start;
        logic       mc_busy;
        logic       mc_wb;
        logic [3:0] wb_rd;
    } out_t;

    logic       clk;
    logic       rst_n;
    logic       ifid_valid;
    logic [3:0] ifid_rs;
    logic [3:0] ifid_rt;
    logic       ifid_uses_rs;
    logic       ifid_uses_rt;
    logic [3:0] ifid_rd;
    logic       ifid_regwrite;
    logic       ifid_multicycle;
    logic       idex_memread;
    logic [3:0] idex_rt;
    logic       flush;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_bubble;
    logic       mc_start;
    logic       mc_busy;
    logic       mc_wb;
    logic [3:0] mc_wb_rd;

    int    n_tests = 0;
    int    n_fail  = 0;
    out_t  exp_q[$];
    out_t  obs_q[$];
    string name_q[$];

    hazard_control_unit #(
        .MC_LATENCY (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_ifid_valid      (ifid_valid),
        .i_ifid_rs         (ifid_rs),
        .i_ifid_rt         (ifid_rt),
        .i_ifid_uses_rs    (ifid_uses_rs),
        .i_ifid_uses_rt    (ifid_uses_rt),
        .i_ifid_rd         (ifid_rd),
        .i_ifid_regwrite   (ifid_regwrite),
        .i_ifid_multicycle (ifid_multicycle),
        .i_idex_memread    (idex_memread),
        .i_idex_rt         (idex_rt),
        .i_flush           (flush),
        .o_pc_write        (pc_write),
        .o_ifid_write      (ifid_write),
        .o_idex_bubble     (idex_bubble),
        .o_mc_start        (mc_start),
        .o_mc_busy         (mc_busy),
        .o_mc_wb           (mc_wb),
        .o_mc_wb_rd        (mc_wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t ex(input logic pc, input logic ifw, input logic bub,
                                input logic st, input logic busy, input logic wb,
                                input logic [3:0] rd);
        out_t o;
        o = {pc, ifw, bub, st, busy, wb, rd};
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o = {pc_write, ifid_write, idex_bubble, mc_start, mc_busy, mc_wb, mc_wb_rd};
        return o;
    endfunction

    // One cycle: drive after the rising edge, queue the expectation,
    // capture the outputs mid-cycle on the falling edge.
    task automatic drv(input string nm, input logic v,
                       input logic [3:0] rs, input logic [3:0] rt,
                       input logic urs, input logic urt,
                       input logic [3:0] rd, input logic rw, input logic mc,
                       input logic mr, input logic [3:0] xrt, input logic fl,
                       input out_t e);
        @(posedge clk);
        #1;
        ifid_valid = v;  ifid_rs = rs;  ifid_rt = rt;
        ifid_uses_rs = urs;  ifid_uses_rt = urt;
        ifid_rd = rd;  ifid_regwrite = rw;  ifid_multicycle = mc;
        idex_memread = mr;  idex_rt = xrt;  flush = fl;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        obs_q.push_back(sample());
    endtask

    task automatic test_reset();
        out_t o;
        ifid_valid = 1'b0; ifid_rs = 4'd0; ifid_rt = 4'd0;
        ifid_uses_rs = 1'b0; ifid_uses_rt = 1'b0; ifid_rd = 4'd0;
        ifid_regwrite = 1'b0; ifid_multicycle = 1'b0;
        idex_memread = 1'b0; idex_rt = 4'd0; flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        o = sample();
        n_tests++;
        if (o !== ex(1, 1, 0, 0, 0, 0, 4'd0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", o, ex(1, 1, 0, 0, 0, 0, 4'd0));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        out_t e, o;
        string nm;
        drv("lu_rs_stall",   1, 4'd3, 4'd0, 1, 0, 4'd4, 1, 0, 1, 4'd3, 0, ex(0, 0, 1, 0, 0, 0, 4'd0));
        drv("lu_advance",    1, 4'd3, 4'd0, 1, 0, 4'd4, 1, 0, 0, 4'd3, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        drv("lu_r0_nostall", 1, 4'd0, 4'd0, 1, 0, 4'd4, 1, 0, 1, 4'd0, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        drv("lu_rt_unused",  1, 4'd1, 4'd3, 1, 0, 4'd4, 1, 0, 1, 4'd3, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        drv("lu_rt_stall",   1, 4'd1, 4'd3, 1, 1, 4'd4, 1, 0, 1, 4'd3, 0, ex(0, 0, 1, 0, 0, 0, 4'd0));
        drv("lu_idle",       0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, o, e);
            end
        end
    endtask

    task automatic test_multicycle();
        out_t e, o;
        string nm;
        drv("mc_issue", 1, 4'd1, 4'd2, 1, 1, 4'd5, 1, 1, 0, 4'd0, 0, ex(1, 1, 0, 1, 0, 0, 4'd0));
        for (int i = 1; i <= 3; i++)
            drv("mc_raw_stall", 1, 4'd5, 4'd0, 1, 0, 4'd7, 1, 0, 0, 4'd0, 0, ex(0, 0, 1, 0, 1, 0, 4'd0));
        drv("mc_raw_wb",   1, 4'd5, 4'd0, 1, 0, 4'd7, 1, 0, 0, 4'd0, 0, ex(0, 0, 1, 0, 1, 1, 4'd5));
        drv("mc_raw_adv",  1, 4'd5, 4'd0, 1, 0, 4'd7, 1, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, o, e);
            end
        end
    endtask

    task automatic test_waw_structural();
        out_t e, o;
        string nm;
        drv("ws_issue",      1, 4'd1, 4'd2, 1, 1, 4'd5, 1, 1, 0, 4'd0, 0, ex(1, 1, 0, 1, 0, 0, 4'd0));
        drv("ws_waw_stall",  1, 4'd1, 4'd2, 1, 1, 4'd5, 1, 0, 0, 4'd0, 0, ex(0, 0, 1, 0, 1, 0, 4'd0));
        drv("ws_struct",     1, 4'd1, 4'd2, 1, 1, 4'd8, 1, 1, 0, 4'd0, 0, ex(0, 0, 1, 0, 1, 0, 4'd0));
        drv("ws_indep",      1, 4'd1, 4'd2, 1, 1, 4'd6, 1, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("ws_wb",         0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 1, 4'd5));
        drv("ws_idle",       0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        string nm;
        // Op A writes nothing: no RAW tracking, no writeback strobe
        drv("bb_issue_a",   1, 4'd1, 4'd2, 1, 1, 4'd10, 0, 1, 0, 4'd0, 0, ex(1, 1, 0, 1, 0, 0, 4'd0));
        drv("bb_busy_a",    0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("bb_nowr_read", 1, 4'd10, 4'd0, 1, 0, 4'd3, 1, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("bb_busy_a2",   0, 4'd0, 4'd0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("bb_last_struct", 1, 4'd1, 4'd2, 1, 1, 4'd0, 1, 1, 0, 4'd0, 0, ex(0, 0, 1, 0, 1, 0, 4'd0));
        // Op B targets r0: issues right after A, never creates a dependency
        drv("bb_issue_b",   1, 4'd1, 4'd2, 1, 1, 4'd0, 1, 1, 0, 4'd0, 0, ex(1, 1, 0, 1, 0, 0, 4'd0));
        drv("bb_r0_read",   1, 4'd0, 4'd0, 1, 1, 4'd0, 1, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("bb_busy_b",    0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("bb_busy_b2",   0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("bb_last_b",    0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("bb_idle",      0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, o, e);
            end
        end
    endtask

    task automatic test_flush();
        out_t e, o;
        string nm;
        drv("fl_loaduse",  1, 4'd3, 4'd0, 1, 0, 4'd4, 1, 0, 1, 4'd3, 1, ex(1, 1, 1, 0, 0, 0, 4'd0));
        drv("fl_mc_noiss", 1, 4'd1, 4'd2, 1, 1, 4'd4, 1, 1, 0, 4'd0, 1, ex(1, 1, 1, 0, 0, 0, 4'd0));
        drv("fl_issue",    1, 4'd1, 4'd2, 1, 1, 4'd4, 1, 1, 0, 4'd0, 0, ex(1, 1, 0, 1, 0, 0, 4'd0));
        drv("fl_in_busy",  1, 4'd4, 4'd0, 1, 0, 4'd4, 1, 1, 0, 4'd0, 1, ex(1, 1, 1, 0, 1, 0, 4'd0));
        drv("fl_busy2",    0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("fl_busy3",    0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("fl_wb_kept",  0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 1, 4'd4));
        drv("fl_idle",     0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t e, o;
        string nm;
        logic  busy_now;
        drv("rm_issue", 1, 4'd1, 4'd2, 1, 1, 4'd5, 1, 1, 0, 4'd0, 0, ex(1, 1, 0, 1, 0, 0, 4'd0));
        drv("rm_busy3", 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        drv("rm_busy2", 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        // Counter now holds 2; pull reset mid-cycle, away from any clock edge
        #2 rst_n = 1'b0;
        #1 busy_now = mc_busy;
        n_tests++;
        if (busy_now !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_async_drop: mc_busy got %b expected 0", busy_now);
        end
        #1 rst_n = 1'b1;
        drv("rm_no_wb1", 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        drv("rm_no_wb2", 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        drv("rm_no_wb3", 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 0, 0, 4'd0));
        drv("rm_reissue", 1, 4'd1, 4'd2, 1, 1, 4'd6, 1, 1, 0, 4'd0, 0, ex(1, 1, 0, 1, 0, 0, 4'd0));
        drv("rm_busy",   0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, ex(1, 1, 0, 0, 1, 0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multicycle();
        test_waw_structural();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hazard_control_unit
`default_nettype wire
